// File: rtl/rv_regfile_sb_if.sv
// Register-file bus: write-back ports, read ports, issue/scoreboard set and ready.
// The master side (decode/issue and write-back) drives the requests and the
// slave side (the register file) returns read data, busy flags and ready.
interface rv_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                    wr0_en;
  logic [ADDR_W-1:0]       wr0_addr;
  logic [DATA_W-1:0]       wr0_data;
  logic                    wr1_en;
  logic [ADDR_W-1:0]       wr1_addr;
  logic [DATA_W-1:0]       wr1_data;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_busy;
  logic                    iss_en;
  logic [ADDR_W-1:0]       iss_addr;
  logic                    ready;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: integer register file with NRD read ports, two prioritised
// write-back ports (LSU over ALU) and a per-register busy scoreboard.
// Storage is cleared by a one-entry-per-cycle sweep after reset so it can map
// onto RAM-style storage. Define RF_BYPASS_EN to forward same-cycle write data
// to the read ports; otherwise reads see stored contents only.

// One read lane: masks x0 and the init sweep, optionally forwards write data.
module rv_regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              busy_q,
`ifdef RF_BYPASS_EN
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
`endif
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  // Read mux: x0 and INIT read as zero; busy never sees same-cycle updates.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (run && addr != '0) begin
      data = mem_q;
      busy = busy_q;
`ifdef RF_BYPASS_EN
      if (we1 && wa1 == addr)      data = wd1;
      else if (we0 && wa0 == addr) data = wd0;
`endif
    end
  end
endmodule

module rv_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic           clk,
  input  logic           rst,
  rv_regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic                   ready_q;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]       busy_q;
  logic                   run;
  logic                   we0, we1;
  logic [NRD-1:0][DATA_W-1:0] rd_data_v;
  logic [NRD-1:0]         rd_busy_v;

  assign run = (state_q == S_RUN);
  // x0 writes are dropped here so storage and scoreboard never touch entry 0.
  assign we0 = run && !rst && bus.wr0_en && (bus.wr0_addr != '0);
  assign we1 = run && !rst && bus.wr1_en && (bus.wr1_addr != '0);

  // State, sweep pointer and ready registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == S_RUN);
    end
  end

  // Next state: sweep every entry once, then stay in RUN until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH-1)) state_d = S_RUN;
      end
      S_RUN:   ;
      default: state_d = S_INIT;
    endcase
  end

  // Storage: no reset; cleared by the sweep, LSU write lands last so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem[ptr_q] <= '0;
      end else begin
        if (we0) mem[bus.wr0_addr] <= bus.wr0_data;
        if (we1) mem[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  // Scoreboard: writes clear, issue sets afterwards so set wins on a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (run) begin
      if (we0) busy_q[bus.wr0_addr] <= 1'b0;
      if (we1) busy_q[bus.wr1_addr] <= 1'b0;
      if (bus.iss_en && bus.iss_addr != '0) busy_q[bus.iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
    rv_regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .run    (run),
      .addr   (ra),
      .mem_q  (mem[ra]),
      .busy_q (busy_q[ra]),
`ifdef RF_BYPASS_EN
      .we0    (we0),
      .wa0    (bus.wr0_addr),
      .wd0    (bus.wr0_data),
      .we1    (we1),
      .wa1    (bus.wr1_addr),
      .wd1    (bus.wr1_data),
`endif
      .data   (rd_data_v[k]),
      .busy   (rd_busy_v[k])
    );
  end

  assign bus.rd_data = rd_data_v;
  assign bus.rd_busy = rd_busy_v;
  assign bus.ready   = ready_q;
endmodule

// File: tb/tb_rv_regfile_sb.sv
// Bench for rv_regfile_sb: directed scenarios plus a randomized run, all
// checked against an array-based model of the register file.
module tb_rv_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bif ();

  rv_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // Reference model: register contents, busy bits, init cycle count.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_run = 1'b0;
  int            m_cnt = 0;

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (bif.wr0_en && bif.wr0_addr != 0) begin
        m_mem[bif.wr0_addr] = bif.wr0_data;
        m_busy[bif.wr0_addr] = 1'b0;
      end
      if (bif.wr1_en && bif.wr1_addr != 0) begin
        m_mem[bif.wr1_addr] = bif.wr1_data;
        m_busy[bif.wr1_addr] = 1'b0;
      end
      if (bif.iss_en && bif.iss_addr != 0) m_busy[bif.iss_addr] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(int k);
    logic [AW-1:0] a;
    a = bif.rd_addr[k*AW +: AW];
    if (!m_run || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (bif.wr1_en && bif.wr1_addr == a) return bif.wr1_data;
    if (bif.wr0_en && bif.wr0_addr == a) return bif.wr0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int k);
    logic [AW-1:0] a;
    a = bif.rd_addr[k*AW +: AW];
    if (!m_run || a == 0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bif.wr0_en = 1'b0; bif.wr0_addr = '0; bif.wr0_data = '0;
    bif.wr1_en = 1'b0; bif.wr1_addr = '0; bif.wr1_data = '0;
    bif.iss_en = 1'b0; bif.iss_addr = '0;
  endtask

  task automatic rand_inputs(int amax);
    bif.wr0_en = 1'($urandom_range(0, 1)); bif.wr0_addr = AW'($urandom_range(0, amax));
    bif.wr0_data = $urandom;
    bif.wr1_en = 1'($urandom_range(0, 1)); bif.wr1_addr = AW'($urandom_range(0, amax));
    bif.wr1_data = $urandom;
    bif.iss_en = 1'($urandom_range(0, 1)); bif.iss_addr = AW'($urandom_range(0, amax));
    for (int k = 0; k < NR; k++) bif.rd_addr[k*AW +: AW] = AW'($urandom_range(0, amax));
  endtask

  task automatic test_reset();
    idle();
    bif.rd_addr = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < NR; k++) bif.rd_addr[k*AW +: AW] = AW'(k + 1);
    #1;
    n_tests++;
    if (bif.ready !== 1'b0) begin
      $display("FAIL reset_ready: got %b exp 0", bif.ready); n_fail++;
    end
    n_tests++;
    if (bif.rd_data !== '0 || bif.rd_busy !== '0) begin
      $display("FAIL reset_read: data %h busy %b exp 0", bif.rd_data, bif.rd_busy); n_fail++;
    end
  endtask

  task automatic test_init_sweep();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs(DEPTH - 1);
      #1;
      n_tests++;
      if (bif.ready !== 1'b0 || bif.rd_data !== '0 || bif.rd_busy !== '0) begin
        $display("FAIL init_cycle%0d: ready %b data %h busy %b exp 0", i, bif.ready, bif.rd_data, bif.rd_busy);
        n_fail++;
      end
      tick();
    end
    idle();
    #1;
    n_tests++;
    if (bif.ready !== 1'b1) begin
      $display("FAIL init_ready: got %b exp 1", bif.ready); n_fail++;
    end
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int k = 0; k < NR; k++) bif.rd_addr[k*AW +: AW] = AW'(a + k);
      #1;
      n_tests++;
      if (bif.rd_data !== '0 || bif.rd_busy !== '0) begin
        $display("FAIL init_cleared x%0d: data %h busy %b exp 0", a, bif.rd_data, bif.rd_busy); n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); tick();
    n_tests++;
    if (bif.ready !== 1'b0) begin
      $display("FAIL midsweep_ready: got %b exp 0", bif.ready); n_fail++;
    end
    rst = 1'b0;
    n = 0;
    while (bif.ready !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++;
    if (n != DEPTH) begin
      $display("FAIL midsweep_latency: got %0d cycles exp %0d", n, DEPTH); n_fail++;
    end
  endtask

  task automatic test_bypass_off();
    logic [DW-1:0] exp0;
    idle();
    bif.rd_addr = {AW'(3), AW'(3)};
    bif.wr0_en = 1'b1; bif.wr0_addr = 5'd3; bif.wr0_data = 32'hA5A5A5A5;
`ifdef RF_BYPASS_EN
    exp0 = 32'hA5A5A5A5;
`else
    exp0 = 32'h0;
`endif
    #1;
    n_tests++;
    if (bif.rd_data[0 +: DW] !== exp0) begin
      $display("FAIL bypass_same_cycle: got %h exp %h", bif.rd_data[0 +: DW], exp0); n_fail++;
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_data[DW +: DW] !== 32'hA5A5A5A5) begin
      $display("FAIL bypass_next_cycle: got %h exp a5a5a5a5", bif.rd_data[DW +: DW]); n_fail++;
    end
  endtask

  task automatic test_write_collision();
    logic [DW-1:0] exp0;
    idle();
    bif.rd_addr = {AW'(5), AW'(5)};
    bif.wr0_en = 1'b1; bif.wr0_addr = 5'd5; bif.wr0_data = 32'h11111111;
    bif.wr1_en = 1'b1; bif.wr1_addr = 5'd5; bif.wr1_data = 32'h22222222;
`ifdef RF_BYPASS_EN
    exp0 = 32'h22222222;
`else
    exp0 = 32'h0;
`endif
    #1;
    n_tests++;
    if (bif.rd_data[0 +: DW] !== exp0) begin
      $display("FAIL collision_same_cycle: got %h exp %h", bif.rd_data[0 +: DW], exp0); n_fail++;
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_data[0 +: DW] !== 32'h22222222) begin
      $display("FAIL collision_next: got %h exp 22222222", bif.rd_data[0 +: DW]); n_fail++;
    end
  endtask

  task automatic test_x0();
    idle();
    bif.rd_addr = '0;
    bif.wr0_en = 1'b1; bif.wr0_addr = '0; bif.wr0_data = 32'hDEADBEEF;
    bif.wr1_en = 1'b1; bif.wr1_addr = '0; bif.wr1_data = 32'hDEADBEEF;
    bif.iss_en = 1'b1; bif.iss_addr = '0;
    #1;
    n_tests++;
    if (bif.rd_data !== '0) begin
      $display("FAIL x0_same_cycle: got %h exp 0", bif.rd_data); n_fail++;
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_data !== '0 || bif.rd_busy !== '0) begin
      $display("FAIL x0_after: data %h busy %b exp 0", bif.rd_data, bif.rd_busy); n_fail++;
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bif.rd_addr = {AW'(0), AW'(7)};
    bif.iss_en = 1'b1; bif.iss_addr = 5'd7;
    #1;
    n_tests++;
    if (bif.rd_busy[0] !== 1'b0) begin
      $display("FAIL sb_same_cycle: got %b exp 0", bif.rd_busy[0]); n_fail++;
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_issue: got %b exp 1", bif.rd_busy[0]); n_fail++;
    end
    bif.wr1_en = 1'b1; bif.wr1_addr = 5'd7; bif.wr1_data = 32'h77;
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_busy[0] !== 1'b0) begin
      $display("FAIL sb_clear: got %b exp 0", bif.rd_busy[0]); n_fail++;
    end
    bif.iss_en = 1'b1; bif.iss_addr = 5'd7;
    bif.wr0_en = 1'b1; bif.wr0_addr = 5'd7; bif.wr0_data = 32'h78;
    tick();
    idle();
    #1;
    n_tests++;
    if (bif.rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_set_wins: got %b exp 1", bif.rd_busy[0]); n_fail++;
    end
    n_tests++;
    if (bif.rd_data[0 +: DW] !== 32'h78) begin
      $display("FAIL sb_set_wins_data: got %h exp 78", bif.rd_data[0 +: DW]); n_fail++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs((c < 200) ? 7 : DEPTH - 1);
      #1;
      for (int k = 0; k < NR; k++) begin
        n_tests++;
        if (bif.rd_data[k*DW +: DW] !== exp_data(k) || bif.rd_busy[k] !== exp_busy(k)) begin
          $display("FAIL rand_c%0d_p%0d: data %h busy %b exp %h %b", c, k,
                   bif.rd_data[k*DW +: DW], bif.rd_busy[k], exp_data(k), exp_busy(k));
          n_fail++;
        end
      end
      n_tests++;
      if (bif.ready !== m_run) begin
        $display("FAIL rand_ready_c%0d: got %b exp %b", c, bif.ready, m_run); n_fail++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_reset_mid_sweep();
    test_bypass_off();
    test_write_collision();
    test_x0();
    test_scoreboard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
